// File: rtl/uart_fifo_ctrl_if.sv
// CPU-side bus of the buffered UART: FIFO push/pop strobes, fill counts and sticky error flags.
interface uart_fifo_ctrl_if #(parameter int DEPTH_LOG2 = 8);
    logic [7:0]          o_read_data;
    logic                i_read_enable;
    logic [7:0]          i_write_data;
    logic                i_write_enable;
    logic [DEPTH_LOG2:0] o_rx_count;
    logic [DEPTH_LOG2:0] o_tx_count;
    logic                o_rx_overflow;
    logic                o_tx_overflow;
    logic                o_frame_error;
    logic                i_clear_errors;

    modport master (
        input  o_read_data, o_rx_count, o_tx_count, o_rx_overflow, o_tx_overflow, o_frame_error,
        output i_read_enable, i_write_data, i_write_enable, i_clear_errors
    );
    modport slave (
        output o_read_data, o_rx_count, o_tx_count, o_rx_overflow, o_tx_overflow, o_frame_error,
        input  i_read_enable, i_write_data, i_write_enable, i_clear_errors
    );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// Buffered 8N1 UART with power-of-two TX/RX FIFOs and sticky error flags.
// Define UART_PARITY_EN to add a parity bit (sense set by ODD_PARITY) to both directions.
module uart_fifo_ctrl #(
    parameter int CLK_HZ     = 16_000_000,
    parameter int BAUD       = 115_200,
    parameter int DEPTH_LOG2 = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    uart_fifo_ctrl_if.slave bus,
    output logic            o_tx,
    input  logic            i_rx_unsafe
);
    localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW    = $clog2(DIV);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0]         BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0]         HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [DEPTH_LOG2:0]   FULL      = (DEPTH_LOG2 + 1)'(DEPTH);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

    logic [7:0]            tx_mem [DEPTH];
    logic [7:0]            rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
    logic [DEPTH_LOG2:0]   tx_count_q, tx_count_d, rx_count_q, rx_count_d;
    logic                  tx_push, tx_pop, rx_push, rx_pop, rx_push_req;
    logic                  tx_ovf_q, rx_ovf_q, ferr_q, ferr_set;

    state_e          tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic            tx_q, tx_d;
    logic            rx_s1_q, rx_s2_q, rx_prev_q;
`ifdef UART_PARITY_EN
    logic            tx_par_q, tx_par_d, rx_pbad_q, rx_pbad_d;
`endif

    // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
    always_comb begin
        tx_push    = bus.i_write_enable && (tx_count_q != FULL || tx_pop);
        rx_pop     = bus.i_read_enable && (rx_count_q != '0);
        rx_push    = rx_push_req && (rx_count_q != FULL || rx_pop);
        tx_count_d = tx_count_q + (DEPTH_LOG2 + 1)'(tx_push) - (DEPTH_LOG2 + 1)'(tx_pop);
        rx_count_d = rx_count_q + (DEPTH_LOG2 + 1)'(rx_push) - (DEPTH_LOG2 + 1)'(rx_pop);
    end

    always_ff @(posedge i_clk) begin
        if (tx_push) tx_mem[tx_wptr_q] <= bus.i_write_data;
        if (rx_push) rx_mem[rx_wptr_q] <= rx_shift_q;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            tx_count_q <= '0;
            rx_count_q <= '0;
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
            if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
            tx_count_q <= tx_count_d;
            rx_count_q <= rx_count_d;
            if (bus.i_write_enable && !tx_push) tx_ovf_q <= 1'b1;
            else if (bus.i_clear_errors)        tx_ovf_q <= 1'b0;
            if (rx_push_req && !rx_push)        rx_ovf_q <= 1'b1;
            else if (bus.i_clear_errors)        rx_ovf_q <= 1'b0;
            if (ferr_set)                       ferr_q   <= 1'b1;
            else if (bus.i_clear_errors)        ferr_q   <= 1'b0;
        end
    end

    assign bus.o_read_data   = (rx_count_q == '0) ? 8'h00 : rx_mem[rx_rptr_q];
    assign bus.o_rx_count    = rx_count_q;
    assign bus.o_tx_count    = tx_count_q;
    assign bus.o_tx_overflow = tx_ovf_q;
    assign bus.o_rx_overflow = rx_ovf_q;
    assign bus.o_frame_error = ferr_q;
    assign o_tx              = tx_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
            rx_pbad_q  <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_s1_q    <= i_rx_unsafe;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
            rx_pbad_q  <= rx_pbad_d;
`endif
        end
    end

    // tx_d is the line level for the next cycle; the stop bit chains straight into the next start.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = (tx_cnt_q != '0) ? tx_cnt_q - 1'b1 : tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            S_IDLE:  tx_pop = (tx_count_q != '0);
            S_START: if (tx_cnt_q == '0) begin
                tx_state_d = S_DATA;
                tx_cnt_d   = BIT_LAST;
                tx_bit_d   = '0;
                tx_d       = tx_shift_q[0];
            end
            S_DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d = BIT_LAST;
                if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                    tx_state_d = S_PARITY;
                    tx_d       = tx_par_q;
`else
                    tx_state_d = S_STOP;
                    tx_d       = 1'b1;
`endif
                end else begin
                    tx_bit_d   = tx_bit_q + 1'b1;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_d       = tx_shift_q[1];
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: if (tx_cnt_q == '0) begin
                tx_state_d = S_STOP;
                tx_cnt_d   = BIT_LAST;
                tx_d       = 1'b1;
            end
`endif
            S_STOP: if (tx_cnt_q == '0) begin
                if (tx_count_q != '0) tx_pop = 1'b1;
                else                  tx_state_d = S_IDLE;
            end
            default: tx_state_d = S_IDLE;
        endcase
        if (tx_pop) begin
            tx_state_d = S_START;
            tx_cnt_d   = BIT_LAST;
            tx_shift_d = tx_mem[tx_rptr_q];
            tx_d       = 1'b0;
`ifdef UART_PARITY_EN
            tx_par_d   = (^tx_mem[tx_rptr_q]) ^ ODD_PARITY;
`endif
        end
    end

    // Samples land mid-bit: half a bit after the synchronised falling edge, then every DIV cycles.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = (rx_cnt_q != '0) ? rx_cnt_q - 1'b1 : rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push_req = 1'b0;
        ferr_set    = 1'b0;
`ifdef UART_PARITY_EN
        rx_pbad_d   = rx_pbad_q;
`endif
        case (rx_state_q)
            S_IDLE: if (rx_prev_q && !rx_s2_q) begin
                rx_state_d = S_START;
                rx_cnt_d   = HALF_LAST;
            end
            S_START: if (rx_cnt_q == '0) begin
                if (rx_s2_q) rx_state_d = S_IDLE;
                else begin
                    rx_state_d = S_DATA;
                    rx_cnt_d   = BIT_LAST;
                    rx_bit_d   = '0;
                end
            end
            S_DATA: if (rx_cnt_q == '0) begin
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 1'b1;
                rx_cnt_d   = BIT_LAST;
`ifdef UART_PARITY_EN
                if (rx_bit_q == 3'd7) rx_state_d = S_PARITY;
`else
                if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
`endif
            end
`ifdef UART_PARITY_EN
            S_PARITY: if (rx_cnt_q == '0) begin
                rx_pbad_d  = rx_s2_q ^ (^rx_shift_q) ^ ODD_PARITY;
                rx_state_d = S_STOP;
                rx_cnt_d   = BIT_LAST;
            end
            S_STOP: if (rx_cnt_q == '0) begin
                rx_state_d  = S_IDLE;
                rx_push_req = rx_s2_q && !rx_pbad_q;
                ferr_set    = !rx_s2_q || rx_pbad_q;
            end
`else
            S_STOP: if (rx_cnt_q == '0) begin
                rx_state_d  = S_IDLE;
                rx_push_req = rx_s2_q;
                ferr_set    = !rx_s2_q;
            end
`endif
            default: rx_state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl at DIV = 139 with 4-deep FIFOs.
module tb_uart_fifo_ctrl;
    localparam int DIV = 139;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst;
    logic tx;
    logic rx;
    int   n_chk  = 0;
    int   n_fail = 0;

    uart_fifo_ctrl_if #(.DEPTH_LOG2(2)) bus ();

    uart_fifo_ctrl #(
        .CLK_HZ(16_000_000), .BAUD(115_200), .DEPTH_LOG2(2), .ODD_PARITY(1'b0)
    ) dut (
        .i_clk(clk), .i_reset(rst), .bus(bus), .o_tx(tx), .i_rx_unsafe(rx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] d);
        bus.i_write_data   = d;
        bus.i_write_enable = 1'b1;
        cyc(1);
        bus.i_write_enable = 1'b0;
    endtask

    task automatic pop();
        bus.i_read_enable = 1'b1;
        cyc(1);
        bus.i_read_enable = 1'b0;
    endtask

    task automatic clr();
        bus.i_clear_errors = 1'b1;
        cyc(1);
        bus.i_clear_errors = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        cyc(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            cyc(DIV);
        end
`ifdef UART_PARITY_EN
        rx = ^d;
        cyc(DIV);
`endif
        rx = stop;
        cyc(DIV);
        rx = 1'b1;
        cyc(DIV);
    endtask

    task automatic wait_tx_low(input string tag);
        int n = 0;
        while (tx !== 1'b0 && n < 100) begin
            cyc(1);
            n++;
        end
        chk(tag, tx, 1'b0);
    endtask

    // t = 0 is the first sample with the start bit on the line; bit k spans [k*DIV, k*DIV+DIV-1].
    task automatic tx_frame(input logic [7:0] d);
        logic [NB-1:0] b;
        b[0]    = 1'b0;
        b[8:1]  = d;
`ifdef UART_PARITY_EN
        b[9]    = ^d;
`endif
        b[NB-1] = 1'b1;
        wait_tx_low("tx_start_seen");
        cyc(DIV - 1);
        chk("tx_start_last_cycle", tx, 1'b0);
        cyc(1);
        chk("tx_bit0_first_cycle", tx, d[0]);
        cyc(DIV / 2);
        for (int k = 1; k < NB; k++) begin
            chk($sformatf("tx_bit%0d", k), tx, b[k]);
            cyc(DIV);
        end
        chk("tx_idle_after_frame", tx, 1'b1);
        chk("tx_count_drained", bus.o_tx_count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] worst;
        logic        tx_at;
        logic [7:0]  d;
        rst = 1'b1;
        rx  = 1'b1;
        bus.i_read_enable  = 1'b0;
        bus.i_write_enable = 1'b0;
        bus.i_write_data   = 8'h00;
        bus.i_clear_errors = 1'b0;
        cyc(3);
        chk("rst_tx", tx, 1'b1);
        chk("rst_tx_count", bus.o_tx_count, 0);
        chk("rst_rx_count", bus.o_rx_count, 0);
        chk("rst_flags", {bus.o_rx_overflow, bus.o_tx_overflow, bus.o_frame_error}, 0);
        chk("rst_read_data", bus.o_read_data, 8'h00);
        rst = 1'b0;
        cyc(2);

        wr(8'hA5);
        tx_frame(8'hA5);

        // TX busy with 0x11, so five writes fill four slots and drop the fifth.
        wr(8'h11);
        cyc(3);
        chk("ovf_tx_busy_count", bus.o_tx_count, 0);
        for (int i = 1; i <= 5; i++) begin
            bus.i_write_data   = 8'(i);
            bus.i_write_enable = 1'b1;
            cyc(1);
            chk($sformatf("ovf_count_%0d", i), bus.o_tx_count, (i > 4) ? 4 : i);
            chk($sformatf("ovf_flag_%0d", i), bus.o_tx_overflow, (i == 5));
        end
        bus.i_write_enable = 1'b0;
        clr();
        chk("ovf_cleared", bus.o_tx_overflow, 1'b0);
        chk("ovf_count_kept", bus.o_tx_count, 4);
        bus.i_write_enable = 1'b1;
        bus.i_clear_errors = 1'b1;
        cyc(1);
        bus.i_clear_errors = 1'b0;
        chk("ovf_set_beats_clear", bus.o_tx_overflow, 1'b1);

        // Keep pushing into the full FIFO across the end of the 0x11 frame.
        bus.i_write_data = 8'h77;
        worst = 32'd4;
        tx_at = 1'b1;
        for (int i = 1; i <= 1500; i++) begin
            cyc(1);
            if (bus.o_tx_count != 3'd4 && worst == 32'd4) worst = 32'(bus.o_tx_count);
            if (i == 1450) tx_at = tx;
        end
        bus.i_write_enable = 1'b0;
        chk("full_push_pop_count", worst, 4);
        chk("next_frame_started", tx_at, 1'b0);

        chk("pre_reset_tx_low", tx, 1'b0);
        #2 rst = 1'b1;
        #1 chk("reset_tx_async", tx, 1'b1);
        cyc(2);
        rst = 1'b0;
        cyc(1);
        chk("post_reset_tx_count", bus.o_tx_count, 0);
        chk("post_reset_flags", {bus.o_rx_overflow, bus.o_tx_overflow, bus.o_frame_error}, 0);
        chk("post_reset_tx_idle", tx, 1'b1);

        send(8'h3C, 1'b1);
        chk("rx_count_one", bus.o_rx_count, 1);
        chk("rx_data_3c", bus.o_read_data, 8'h3C);
        pop();
        chk("rx_count_zero", bus.o_rx_count, 0);
        chk("rx_empty_data", bus.o_read_data, 8'h00);

        send(8'h55, 1'b0);
        chk("frame_err_set", bus.o_frame_error, 1'b1);
        chk("frame_err_dropped", bus.o_rx_count, 0);
        send(8'h12, 1'b1);
        chk("after_ferr_count", bus.o_rx_count, 1);
        chk("after_ferr_data", bus.o_read_data, 8'h12);
        chk("frame_err_sticky", bus.o_frame_error, 1'b1);
        pop();
        clr();
        chk("frame_err_cleared", bus.o_frame_error, 1'b0);

        for (int i = 0; i < 10; i++) begin
            d = 8'h40 + 8'(i * 19);
            send(d, 1'b1);
            chk($sformatf("stream_%0d", i), bus.o_read_data, d);
            pop();
        end
        chk("stream_no_overflow", bus.o_rx_overflow, 1'b0);
        chk("stream_empty", bus.o_rx_count, 0);

        for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), 1'b1);
        chk("rx_full_count", bus.o_rx_count, 4);
        chk("rx_overflow_set", bus.o_rx_overflow, 1'b1);
        chk("rx_full_head", bus.o_read_data, 8'hA0);
        pop();
        chk("rx_next_head", bus.o_read_data, 8'hA1);
        chk("rx_count_after_pop", bus.o_rx_count, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
